// File: rtl/udma_evt_collector_if.sv
// Event collector bus: uDMA pulse lines in, event-ID valid/ready stream and loss report out.
interface udma_evt_collector_if #(
  parameter int unsigned N_LINES = 128
);
  logic [N_LINES-1:0] events_i;
  logic               evt_valid_o;
  logic [7:0]         evt_data_o;
  logic               evt_ready_i;
  logic               evt_lost_o;
  logic               lost_clr_i;
  logic [7:0]         lost_id_o;

  modport master (
    input  events_i, evt_ready_i, lost_clr_i,
    output evt_valid_o, evt_data_o, evt_lost_o, lost_id_o
  );

  modport slave (
    output events_i, evt_ready_i, lost_clr_i,
    input  evt_valid_o, evt_data_o, evt_lost_o, lost_id_o
  );
endinterface

// File: rtl/udma_evt_collector.sv
// Converts uDMA event pulses into an 8-bit event-ID stream via pending counters, RR arbiter and FIFO.
// Optional per-line masking is enabled by defining UDMA_EVT_COLLECTOR_MASK_EN.
module udma_evt_collector #(
  parameter int unsigned N_LINES    = 128,
  parameter int unsigned PEND_W     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic sys_clk_i,
  input logic sys_reset_i,
`ifdef UDMA_EVT_COLLECTOR_MASK_EN
  input logic [N_LINES-1:0] evt_mask_i,
`endif
  udma_evt_collector_if.master bus
);

  localparam int unsigned IDX_W = (N_LINES > 1) ? $clog2(N_LINES) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0]  cnt     [N_LINES];
  logic [PEND_W-1:0]  cnt_nxt [N_LINES];
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_found;
  logic [IDX_W:0]     scan_idx;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [N_LINES-1:0] events_en;
  logic [N_LINES-1:0] loss_vec;
  logic               loss_any;
  logic [IDX_W-1:0]   loss_idx;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic               lost;
  logic [7:0]         lost_id;

`ifdef UDMA_EVT_COLLECTOR_MASK_EN
  assign events_en = bus.events_i & ~evt_mask_i;
`else
  assign events_en = bus.events_i;
`endif

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.evt_ready_i;
  assign push  = grant_found && !full;

  // Round-robin search starting at rr_ptr; first line with pending events wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      scan_idx = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (scan_idx >= (IDX_W+1)'(N_LINES)) scan_idx = scan_idx - (IDX_W+1)'(N_LINES);
      if (!grant_found && cnt[IDX_W'(scan_idx)] != '0) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(scan_idx);
      end
    end
  end

  // Pending counter update; a pulse on a saturated, undrained line is a loss
  always_comb begin
    cnt_nxt  = cnt;
    loss_vec = '0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if (events_en[i] && !(push && grant_idx == IDX_W'(i))) begin
        if (cnt[i] == CNT_MAX) loss_vec[i] = 1'b1;
        else                   cnt_nxt[i]  = cnt[i] + PEND_W'(1);
      end else if (!events_en[i] && push && grant_idx == IDX_W'(i)) begin
        cnt_nxt[i] = cnt[i] - PEND_W'(1);
      end
    end
  end

  always_comb begin
    loss_any = |loss_vec;
    loss_idx = '0;
    for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
      if (loss_vec[i]) loss_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      for (int unsigned i = 0; i < N_LINES; i++) cnt[i] <= '0;
      rr_ptr <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (push) rr_ptr <= (grant_idx == IDX_W'(N_LINES - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= 8'(grant_idx);
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Sticky loss flag; a fresh loss overrides a simultaneous clear
  always_ff @(posedge sys_clk_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      lost    <= 1'b0;
      lost_id <= '0;
    end else if (loss_any && (!lost || bus.lost_clr_i)) begin
      lost    <= 1'b1;
      lost_id <= 8'(loss_idx);
    end else if (bus.lost_clr_i) begin
      lost    <= 1'b0;
      lost_id <= '0;
    end
  end

  assign bus.evt_valid_o = !empty;
  assign bus.evt_data_o  = mem[rd_ptr[AW-1:0]];
  assign bus.evt_lost_o  = lost;
  assign bus.lost_id_o   = lost_id;

endmodule
